// File: rtl/dpram_be.sv
// Dual-port RAM with per-byte write enables, registered read data and valid flags.
// Define DPRAM_BE_OUTREG_EN to add a second output register stage (read latency 2).
module dpram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_DEPTH = 2,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_en,
    input  logic                    a_wen,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [WORD_DEPTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_vld,
    input  logic                    b_en,
    input  logic                    b_wen,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [WORD_DEPTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_din,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_vld
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned NumWords = 2 ** WORD_DEPTH;

    if (DATA_WIDTH % 8 != 0) begin : gen_width_check
        $error("dpram_be: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [NumWords];

    logic                  a_we, b_we;
    logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, a_rd_d, b_rd_d;
    logic [DATA_WIDTH-1:0] a_dout_q, b_dout_q;
    logic                  a_vld_q, b_vld_q;

    assign a_we = a_en && a_wen && !reset;
    assign b_we = b_en && b_wen && !reset;

    // a_new/b_new are the final word at each port's address after both writes land;
    // on a shared address they are identical, with port A winning per byte.
    always_comb begin
        a_old = mem_q[a_addr];
        b_old = mem_q[b_addr];
        a_new = a_old;
        b_new = b_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (b_we && b_be[i] && (b_addr == a_addr)) a_new[8*i +: 8] = b_din[8*i +: 8];
            if (a_we && a_be[i])                       a_new[8*i +: 8] = a_din[8*i +: 8];
            if (b_we && b_be[i])                       b_new[8*i +: 8] = b_din[8*i +: 8];
            if (a_we && a_be[i] && (a_addr == b_addr)) b_new[8*i +: 8] = a_din[8*i +: 8];
        end
        // Cross-port reads always see the pre-write word.
        a_rd_d = (RDW_MODE == 1 && a_we) ? a_new : a_old;
        b_rd_d = (RDW_MODE == 1 && b_we) ? b_new : b_old;
    end

    // Memory has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (a_we) mem_q[a_addr] <= a_new;
        if (b_we) mem_q[b_addr] <= b_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout_q <= '0;
            a_vld_q  <= 1'b0;
            b_dout_q <= '0;
            b_vld_q  <= 1'b0;
        end else begin
            a_vld_q <= a_en;
            b_vld_q <= b_en;
            if (a_en) a_dout_q <= a_rd_d;
            if (b_en) b_dout_q <= b_rd_d;
        end
    end

`ifdef DPRAM_BE_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_dout2_q, b_dout2_q;
    logic                  a_vld2_q, b_vld2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout2_q <= '0;
            a_vld2_q  <= 1'b0;
            b_dout2_q <= '0;
            b_vld2_q  <= 1'b0;
        end else begin
            a_dout2_q <= a_dout_q;
            a_vld2_q  <= a_vld_q;
            b_dout2_q <= b_dout_q;
            b_vld2_q  <= b_vld_q;
        end
    end

    assign a_dout = a_dout2_q;
    assign a_vld  = a_vld2_q;
    assign b_dout = b_dout2_q;
    assign b_vld  = b_vld2_q;
`else
    assign a_dout = a_dout_q;
    assign a_vld  = a_vld_q;
    assign b_dout = b_dout_q;
    assign b_vld  = b_vld_q;
`endif

endmodule

// File: tb/tb_dpram_be.sv
// Directed self-checking bench for dpram_be; a second instance runs write-first mode.
module tb_dpram_be;

`ifdef DPRAM_BE_OUTREG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        a_en, a_wen, b_en, b_wen;
    logic [3:0]  a_be, b_be;
    logic [1:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [31:0] a_dout, b_dout, m1_a_dout, m1_b_dout;
    logic        a_vld, b_vld, m1_a_vld, m1_b_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dpram_be #(.DATA_WIDTH(32), .WORD_DEPTH(2), .RDW_MODE(0)) u_dut (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_vld(a_vld),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout), .b_vld(b_vld)
    );

    dpram_be #(.DATA_WIDTH(32), .WORD_DEPTH(2), .RDW_MODE(1)) u_dut_wf (
        .clk(clk), .reset(reset),
        .a_en(a_en), .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(m1_a_dout), .a_vld(m1_a_vld),
        .b_en(b_en), .b_wen(b_wen), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(m1_b_dout), .b_vld(m1_b_vld)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic wen, input logic [3:0] be,
                         input logic [1:0] addr, input logic [31:0] din);
        a_en = en; a_wen = wen; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic en, input logic wen, input logic [3:0] be,
                         input logic [1:0] addr, input logic [31:0] din);
        b_en = en; b_wen = wen; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
        set_b(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    endtask

    task automatic wr_a(input logic [1:0] addr, input logic [31:0] din, input logic [3:0] be);
        set_a(1'b1, 1'b1, be, addr, din);
        step();
        idle();
    endtask

    // Read on port A (pa=1) or B (pa=0), check data/valid at latency, then valid drop and hold.
    task automatic rd(input bit pa, input logic [1:0] addr, input logic [31:0] exp,
                      input string tag);
        if (pa) set_a(1'b1, 1'b0, 4'h0, addr, 32'h0);
        else    set_b(1'b1, 1'b0, 4'h0, addr, 32'h0);
        step();
        idle();
        repeat (Lat - 1) step();
        check({tag, "_dout"}, pa ? a_dout : b_dout, exp);
        check({tag, "_vld"}, {31'b0, pa ? a_vld : b_vld}, 32'd1);
        step();
        check({tag, "_vld_drop"}, {31'b0, pa ? a_vld : b_vld}, 32'd0);
        check({tag, "_hold"}, pa ? a_dout : b_dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_mem [4];
        idle();
        reset = 1'b1;
        step();
        step();
        check("rst_a_dout", a_dout, 32'h0);
        check("rst_b_dout", b_dout, 32'h0);
        check("rst_a_vld", {31'b0, a_vld}, 32'd0);
        check("rst_b_vld", {31'b0, b_vld}, 32'd0);
        reset = 1'b0;
        step();

        // Full-word write then read back on both ports.
        wr_a(2'd1, 32'hDEADBEEF, 4'hF);
        rd(1'b1, 2'd1, 32'hDEADBEEF, "wr_full_a");
        rd(1'b0, 2'd1, 32'hDEADBEEF, "wr_full_b");

        // Partial byte-enable merge.
        wr_a(2'd2, 32'h11223344, 4'hF);
        wr_a(2'd2, 32'hAABBCCDD, 4'b0101);
        rd(1'b1, 2'd2, 32'h11BB33DD, "be_merge");

        // Same-cycle dual write: A wins byte 0, B lands byte 1.
        wr_a(2'd3, 32'h0, 4'hF);
        set_a(1'b1, 1'b1, 4'b0001, 2'd3, 32'h000000FF);
        set_b(1'b1, 1'b1, 4'b0011, 2'd3, 32'h0000FF00);
        step();
        idle();
        rd(1'b1, 2'd3, 32'h0000FFFF, "dual_wr");

        // Cross-port read during write sees the old word.
        set_a(1'b1, 1'b1, 4'hF, 2'd3, 32'h12345678);
        set_b(1'b1, 1'b0, 4'h0, 2'd3, 32'h0);
        step();
        idle();
        repeat (Lat - 1) step();
        check("xport_b_dout", b_dout, 32'h0000FFFF);
        check("xport_b_vld", {31'b0, b_vld}, 32'd1);
        check("xport_a_vld", {31'b0, a_vld}, 32'd1);
        rd(1'b1, 2'd3, 32'h12345678, "xport_after");

        // Same-port read-during-write: read-first vs write-first.
        wr_a(2'd0, 32'h5, 4'hF);
        set_a(1'b1, 1'b1, 4'hF, 2'd0, 32'h9);
        step();
        idle();
        repeat (Lat - 1) step();
        check("rdw0_full", a_dout, 32'h5);
        check("rdw1_full", m1_a_dout, 32'h9);
        set_a(1'b1, 1'b1, 4'b0101, 2'd0, 32'hAABBCCDD);
        step();
        idle();
        repeat (Lat - 1) step();
        check("rdw0_part", a_dout, 32'h9);
        check("rdw1_part", m1_a_dout, 32'h00BB00DD);

        // Reset mid-read: squashed, outputs cleared, memory kept, writes ignored.
        wr_a(2'd0, 32'hCAFEF00D, 4'hF);
        set_a(1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
        step();
        reset = 1'b1;
        set_a(1'b1, 1'b1, 4'hF, 2'd0, 32'h0BAD0BAD);
        set_b(1'b1, 1'b0, 4'h0, 2'd1, 32'h0);
        step();
        check("rst_mid_a_dout", a_dout, 32'h0);
        check("rst_mid_a_vld", {31'b0, a_vld}, 32'd0);
        step();
        step();
        check("rst_end_b_dout", b_dout, 32'h0);
        check("rst_end_b_vld", {31'b0, b_vld}, 32'd0);
        reset = 1'b0;
        idle();
        for (int k = 0; k < Lat + 1; k++) begin
            step();
            check("post_rst_no_vld", {31'b0, a_vld | b_vld}, 32'd0);
        end
        rd(1'b1, 2'd0, 32'hCAFEF00D, "post_rst_rd");

        // Back-to-back reads of every address.
        exp_mem[0] = 32'hCAFEF00D;
        exp_mem[1] = 32'hDEADBEEF;
        exp_mem[2] = 32'h11BB33DD;
        exp_mem[3] = 32'h12345678;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_a(1'b1, 1'b0, 4'h0, 2'(c), 32'h0);
            else       idle();
            step();
            if (c - (Lat - 1) >= 0 && c - (Lat - 1) < 4) begin
                check("b2b_dout", a_dout, exp_mem[c - (Lat - 1)]);
                check("b2b_vld", {31'b0, a_vld}, 32'd1);
            end else if (c - (Lat - 1) >= 4) begin
                check("b2b_vld_off", {31'b0, a_vld}, 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_be.md
DPRAM_BE -- requirements
Module: dpram_be

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; the block SHALL require a multiple of 8, and elaboration SHALL fail otherwise.
REQ-002 Parameter WORD_DEPTH, default 2: address width in bits; the array SHALL hold 2**WORD_DEPTH words.
REQ-003 Parameter RDW_MODE, default 0: same-port read-during-write mode; 0 = read-first (old data), 1 = write-first (new merged data).
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Ports a_en / b_en, input, 1: port enable; no read or write occurs on that port when low.
REQ-007 Ports a_wen / b_wen, input, 1: write when high, read when low; qualified by the port enable.
REQ-008 Ports a_be / b_be, input, DATA_WIDTH/8: byte write enables; bit i covers data bits [8i+7:8i].
REQ-009 Ports a_addr / b_addr, input, WORD_DEPTH: word address.
REQ-010 Ports a_din / b_din, input, DATA_WIDTH: write data.
REQ-011 Ports a_dout / b_dout, output, DATA_WIDTH: read data.
REQ-012 Ports a_vld / b_vld, output, 1: high for exactly one cycle when the port's dout carries the result of an enabled access.

Function
REQ-013 Write (en=1, wen=1): bytes with be[i]=1 SHALL be updated at the clock edge; bytes with be[i]=0 SHALL keep their value; be all-zero SHALL leave the word unchanged.
REQ-014 Read (en=1, wen=0): dout SHALL present mem[addr] one cycle after the access (base latency 1), with vld high in that same cycle.
REQ-015 Write access: dout/vld SHALL also update (latency 1) with the per-RDW_MODE word: pre-write word (mode 0) or post-merge word (mode 1).
REQ-016 en=0: dout SHALL hold its last value and vld SHALL be 0 in the following cycle.
REQ-017 Cross-port read of an address the other port writes in the same cycle SHALL return the pre-write word, regardless of RDW_MODE.
REQ-018 Both ports writing the same address in the same cycle: per byte, port A data SHALL win where a_be[i]=1; port B data SHALL land where only b_be[i]=1.
REQ-019 Address wrap: none; all 2**WORD_DEPTH addresses SHALL be valid and distinct, with no aliasing.
REQ-020 Both ports SHALL operate fully independently every cycle; no stalls and no backpressure.

Reset
REQ-021 While reset=1 at a clock edge: a_dout, b_dout SHALL be 0, a_vld, b_vld SHALL be 0, and all pipeline registers SHALL clear.
REQ-022 Accesses presented while reset=1 SHALL be ignored: no write to memory and no vld.
REQ-023 Memory contents SHALL NOT be cleared by reset; data written before reset SHALL remain readable after.
REQ-024 Reset asserted with a read in flight SHALL squash it: no vld SHALL appear after reset deasserts for that access.

Configuration
REQ-025 Macro DPRAM_BE_OUTREG_EN defined: an extra output register stage per port SHALL be added; read latency = 2 cycles; vld SHALL be delayed identically; that stage SHALL be cleared by reset.
REQ-026 DPRAM_BE_OUTREG_EN undefined: latency SHALL be 1 cycle per REQ-014, and the extra stage SHALL be absent.

Verification (DATA_WIDTH=32, WORD_DEPTH=2, RDW_MODE=0, macro undefined unless stated)
REQ-027 A writes 0xDEADBEEF at addr 1 with be=4'hF, then reads addr 1 -> a_dout=0xDEADBEEF with a_vld=1 exactly one cycle after the read.
REQ-028 addr 2 holds 0x11223344; A writes 0xAABBCCDD with be=4'b0101 -> subsequent read returns 0x11BB33DD.
REQ-029 Same cycle: A writes addr 3 with 0x000000FF (be=4'b0001), B writes addr 3 with 0x0000FF00 (be=4'b0011) -> read returns 0x0000FFFF with byte0 from A; also B reading addr 3 while A writes it -> b_dout shows the old word.
REQ-030 addr 0 holds 0x5; A writes 0x9 with be=4'hF -> a_dout=0x5 next cycle; repeat with RDW_MODE=1 -> a_dout=0x9.
REQ-031 Write 0xCAFEF00D at addr 0; assert reset 3 cycles mid-read; release; read addr 0 -> outputs 0 and vld 0 during reset, no stale vld afterwards, read returns 0xCAFEF00D.
REQ-032 With DPRAM_BE_OUTREG_EN defined, back-to-back reads of addr 0..3 -> a_vld high cycles 2..5 after first read, data in address order.
